// File: rtl/shrink_fifo_lanes_pkg.sv
// shrink_fifo_lanes_pkg: shared overlay constants and width helpers for shrink_fifo_lanes.
// Contents:
//   PORT_IN / PORT_OUT : INPUT_PORT encodings (1 = input-port FIFO, 0 = output-port FIFO)
//   lane_cw(ratio)     : width of the per-word lane count
//   ptr_w(depth_log2)  : FIFO pointer width, one extra wrap bit
package shrink_fifo_lanes_pkg;
  localparam int PORT_IN  = 1;
  localparam int PORT_OUT = 0;
  function automatic int lane_cw(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction
  function automatic int ptr_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction
endpackage

// File: rtl/shrink_fifo_lanes_fifo_mem.sv
// sfl_fifo_mem: distributed-RAM FIFO with combinational read data and occupancy.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en_i, wdata_i   : write strobe (caller guarantees ~full) and data
//   rd_en_i, rdata_o   : read strobe (caller guarantees ~empty), head-of-queue data
//   full_o, empty_o    : status from wrap-bit pointers
//   level_o            : entries in use, wp - rp modulo 2**(ASIZE+1)
module sfl_fifo_mem
  import shrink_fifo_lanes_pkg::*;
#(
  parameter  int DSIZE = 8,
  parameter  int ASIZE = 4,
  localparam int PW    = ptr_w(ASIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    level_o
);
  logic [DSIZE-1:0] mem_q [2**ASIZE];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  always_comb begin
    wp_d = wr_en_i ? wp_q + 1'b1 : wp_q;
    rp_d = rd_en_i ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // Storage is deliberately not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wp_q[ASIZE-1:0]] <= wdata_i;
  end
  assign rdata_o = mem_q[rp_q[ASIZE-1:0]];
  assign full_o  = (wp_q ^ rp_q) == {1'b1, {ASIZE{1'b0}}};
  assign empty_o = wp_q == rp_q;
  assign level_o = wp_q - rp_q;
endmodule

// File: rtl/shrink_fifo_lanes.sv
// shrink_fifo_lanes: buffered wide-to-narrow converter emitting cnt_a+1 lanes per word, LSB lane first.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   d_a, cnt_a, vld_a, rdy_a        : wide input word, valid lanes minus 1, handshake
//   d_b, last_b, vld_b, rdy_b       : output lane, last-lane tag, handshake
//   level                           : FIFO entries in use (staged word excluded)
//   is_done_mode_user               : freezes the performance counters
//   full_cnt, empty_cnt, read_cnt   : performance counters
//   stall_condition                 : stall indicator (meaning selected by INPUT_PORT)
// Build option: define SHRINK_FIFO_PERF_CNT_EN to build the counters and stall indicator;
// otherwise they are tied to zero.
module shrink_fifo_lanes
  import shrink_fifo_lanes_pkg::*;
#(
  parameter  int PAYLOAD_BITS = 32,
  parameter  int IN_WIDTH     = 512,
  parameter  int OUT_WIDTH    = 32,
  parameter  int DEPTH_LOG2   = 5,
  parameter  int INPUT_PORT   = PORT_OUT,
  localparam int RATIO        = IN_WIDTH / OUT_WIDTH,
  localparam int CW           = lane_cw(RATIO),
  localparam int PW           = ptr_w(DEPTH_LOG2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_WIDTH-1:0]     d_a,
  input  logic [CW-1:0]           cnt_a,
  input  logic                    vld_a,
  output logic                    rdy_a,
  output logic [OUT_WIDTH-1:0]    d_b,
  output logic                    last_b,
  output logic                    vld_b,
  input  logic                    rdy_b,
  output logic [PW-1:0]           level,
  input  logic                    is_done_mode_user,
  output logic [PAYLOAD_BITS-1:0] full_cnt,
  output logic [PAYLOAD_BITS-1:0] empty_cnt,
  output logic [PAYLOAD_BITS-1:0] read_cnt,
  output logic                    stall_condition
);
  logic [CW+IN_WIDTH-1:0] rdata;
  logic                   full, empty, wr_en, rd_en, hs;
  logic [IN_WIDTH-1:0]    stg_data_q, stg_data_d;
  logic [CW-1:0]          stg_cnt_q, stg_cnt_d, idx_q, idx_d;
  logic                   stg_vld_q, stg_vld_d;
  logic [OUT_WIDTH-1:0]   lanes [RATIO];
  assign wr_en = vld_a & ~full;
  assign hs    = vld_b & rdy_b;
  // Reloading on the last-lane handshake keeps back-to-back words bubble-free.
  assign rd_en = ~empty & (~stg_vld_q | (hs & last_b));
  sfl_fifo_mem #(
    .DSIZE (CW + IN_WIDTH),
    .ASIZE (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (wr_en),
    .wdata_i ({cnt_a, d_a}),
    .rd_en_i (rd_en),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign lanes[i] = stg_data_q[i*OUT_WIDTH +: OUT_WIDTH];
  end
  assign rdy_a  = ~full;
  assign vld_b  = stg_vld_q;
  assign d_b    = lanes[idx_q];
  // Gated by stg_vld so the idle stage never advertises a last lane.
  assign last_b = stg_vld_q & (idx_q == stg_cnt_q);
  always_comb begin
    stg_data_d = rd_en ? rdata[IN_WIDTH-1:0] : stg_data_q;
    stg_cnt_d  = rd_en ? rdata[CW+IN_WIDTH-1:IN_WIDTH] : stg_cnt_q;
    stg_vld_d  = rd_en | (stg_vld_q & ~(hs & last_b));
    idx_d      = rd_en ? '0 : (hs & ~last_b) ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_q <= '0;
      stg_cnt_q  <= '0;
      stg_vld_q  <= 1'b0;
      idx_q      <= '0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_cnt_q  <= stg_cnt_d;
      stg_vld_q  <= stg_vld_d;
      idx_q      <= idx_d;
    end
  end
`ifdef SHRINK_FIFO_PERF_CNT_EN
  logic [PAYLOAD_BITS-1:0] full_cnt_q, empty_cnt_q, read_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt_q  <= '0;
      empty_cnt_q <= '0;
      read_cnt_q  <= '0;
    end else if (!is_done_mode_user) begin
      if (full) full_cnt_q <= full_cnt_q + 1'b1;
      if (empty & ~stg_vld_q) empty_cnt_q <= empty_cnt_q + 1'b1;
      if (hs) read_cnt_q <= read_cnt_q + 1'b1;
    end
  end
  assign full_cnt        = full_cnt_q;
  assign empty_cnt       = empty_cnt_q;
  assign read_cnt        = read_cnt_q;
  assign stall_condition = ~is_done_mode_user &
                           ((INPUT_PORT == PORT_IN) ? (rdy_b & ~vld_b) : (vld_a & full));
`else
  logic unused;
  assign unused          = ^{is_done_mode_user, INPUT_PORT == PORT_IN};
  assign full_cnt        = '0;
  assign empty_cnt       = '0;
  assign read_cnt        = '0;
  assign stall_condition = 1'b0;
`endif
endmodule
